// File: rtl/vga_pkg.sv
// Shared definitions for the ball-motion engine: screen geometry, ball limits,
// Avalon register addresses, control/dir bit positions, the FSM state type and
// a range clamp helper used when loading shadow positions.
package vga_pkg;

    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 30;
    localparam int INIT_X    = 400;
    localparam int INIT_Y    = 300;

    // Legal range of the ball centre on each axis
    localparam int X_MIN = BALL_SIZE;
    localparam int X_MAX = SCREEN_W - 1 - BALL_SIZE;
    localparam int Y_MIN = BALL_SIZE;
    localparam int Y_MAX = SCREEN_H - 1 - BALL_SIZE;

    localparam logic [9:0] VBLANK_LINE = 10'(SCREEN_H);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_SPEED_X  = 3'd1;
    localparam logic [2:0] ADDR_SPEED_Y  = 3'd2;
    localparam logic [2:0] ADDR_SHX_LO   = 3'd3;
    localparam logic [2:0] ADDR_SHX_HI   = 3'd4;
    localparam logic [2:0] ADDR_SHY_LO   = 3'd5;
    localparam logic [2:0] ADDR_SHY_HI   = 3'd6;
    localparam logic [2:0] ADDR_DIR      = 3'd7;

    localparam int CTRL_RUN_BIT  = 0;
    localparam int CTRL_STEP_BIT = 1;
    localparam int DIR_X_BIT     = 0;
    localparam int DIR_Y_BIT     = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        MOVE_X = 2'd2,
        MOVE_Y = 2'd3
    } state_t;

    function automatic logic [10:0] clamp_pos(input logic [10:0] v,
                                              input logic [10:0] lo,
                                              input logic [10:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis motion step, purely combinational.
//   pos      : current centre position
//   speed    : pixels per frame (0 = hold)
//   dir      : 1 = moving toward MIN, 0 = moving toward MAX
//   next_pos : position after one step, clamped to the edge on a bounce
//   next_dir : direction after the step (flipped on a bounce)
//   hit      : the step reached an edge and reflected
module axis_step #(
    parameter int W   = 11,
    parameter int MIN = 30,
    parameter int MAX = 609
) (
    input  logic [W-1:0] pos,
    input  logic [3:0]   speed,
    input  logic         dir,
    output logic [W-1:0] next_pos,
    output logic         next_dir,
    output logic         hit
);

    localparam logic [W:0] MIN_E = MIN[W:0];
    localparam logic [W:0] MAX_E = MAX[W:0];

    logic [W:0] speed_e;
    logic [W:0] sum;
    logic [W:0] lo_plus;

    // One extra bit of headroom so pos + speed cannot wrap
    assign speed_e = {{(W-3){1'b0}}, speed};
    assign sum     = {1'b0, pos} + speed_e;
    assign lo_plus = MIN_E + speed_e;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        hit      = 1'b0;
        if (speed != 4'd0) begin
            if (!dir) begin
                if (sum >= MAX_E) begin
                    next_pos = MAX_E[W-1:0];
                    next_dir = 1'b1;
                    hit      = 1'b1;
                end else begin
                    next_pos = sum[W-1:0];
                end
            end else begin
                if ({1'b0, pos} <= lo_plus) begin
                    next_pos = MIN_E[W-1:0];
                    next_dir = 1'b0;
                    hit      = 1'b1;
                end else begin
                    next_pos = pos - speed_e[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/ball_motion.sv
// Ball-motion engine. Advances the ball once per frame at the start of
// vertical blank and bounces it off the screen edges; positions can be
// loaded from HPS-written shadow registers.
//   clk, reset_n                         : clock, async active-low reset
//   writedata/write/chipselect/address   : Avalon-MM register writes
//   vcount                               : current line from the VGA counters
//   ball_x, ball_y                       : registered ball centre
//   frame_tick                           : pulse on the first vblank line
//   bounce                               : registered pulse on each reflection
//
//   state  | meaning
//   IDLE   | wait for a frame tick
//   LOAD   | copy clamped shadow position to the ball
//   MOVE_X | step the X axis
//   MOVE_Y | step the Y axis
module ball_motion
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  writedata,
    input  logic        write,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic [9:0]  vcount,
    output logic [10:0] ball_x,
    output logic [9:0]  ball_y,
    output logic        frame_tick,
    output logic        bounce
);

    state_t      state_q, state_d;
    logic [10:0] ball_x_q, ball_x_d;
    logic [9:0]  ball_y_q, ball_y_d;
    logic [3:0]  speed_x_q, speed_x_d;
    logic [3:0]  speed_y_q, speed_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        run_q, run_d;
    logic        step_pending_q, step_pending_d;
    logic        load_pending_q, load_pending_d;
    logic [10:0] shadow_x_q, shadow_x_d;
    logic [9:0]  shadow_y_q, shadow_y_d;
    logic [9:0]  vcount_prev_q;
    logic        bounce_q, bounce_d;

    logic        tick;
    logic        wr_en;
    logic [10:0] x_next;
    logic        x_next_dir, x_hit;
    logic [9:0]  y_next;
    logic        y_next_dir, y_hit;

    assign tick  = (vcount == VBLANK_LINE) && (vcount_prev_q != VBLANK_LINE);
    assign wr_en = chipselect && write;

    axis_step #(.W(11), .MIN(X_MIN), .MAX(X_MAX)) u_step_x (
        .pos      (ball_x_q),
        .speed    (speed_x_q),
        .dir      (dir_x_q),
        .next_pos (x_next),
        .next_dir (x_next_dir),
        .hit      (x_hit)
    );

    axis_step #(.W(10), .MIN(Y_MIN), .MAX(Y_MAX)) u_step_y (
        .pos      (ball_y_q),
        .speed    (speed_y_q),
        .dir      (dir_y_q),
        .next_pos (y_next),
        .next_dir (y_next_dir),
        .hit      (y_hit)
    );

    always_comb begin
        state_d        = state_q;
        ball_x_d       = ball_x_q;
        ball_y_d       = ball_y_q;
        speed_x_d      = speed_x_q;
        speed_y_d      = speed_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        run_d          = run_q;
        step_pending_d = step_pending_q;
        load_pending_d = load_pending_q;
        shadow_x_d     = shadow_x_q;
        shadow_y_d     = shadow_y_q;
        bounce_d       = 1'b0;

        // FSM first, so that register writes below override pending clears
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    if (load_pending_q) begin
                        state_d = LOAD;
                    end else if (run_q || step_pending_q) begin
                        state_d        = MOVE_X;
                        step_pending_d = 1'b0;
                    end
                end
            end
            LOAD: begin
                ball_x_d       = clamp_pos(shadow_x_q, 11'(X_MIN), 11'(X_MAX));
                ball_y_d       = 10'(clamp_pos({1'b0, shadow_y_q},
                                               11'(Y_MIN), 11'(Y_MAX)));
                load_pending_d = 1'b0;
                state_d        = IDLE;
            end
            MOVE_X: begin
                ball_x_d = x_next;
                bounce_d = x_hit;
                state_d  = MOVE_Y;
            end
            MOVE_Y: begin
                ball_y_d = y_next;
                bounce_d = y_hit;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_en) begin
            unique case (address)
                ADDR_CTRL: begin
                    run_d = writedata[CTRL_RUN_BIT];
                    if (writedata[CTRL_STEP_BIT])
                        step_pending_d = 1'b1;
                end
                ADDR_SPEED_X: speed_x_d = writedata[3:0];
                ADDR_SPEED_Y: speed_y_d = writedata[3:0];
                ADDR_SHX_LO: begin
                    shadow_x_d[7:0] = writedata;
                    load_pending_d  = 1'b1;
                end
                ADDR_SHX_HI: begin
                    shadow_x_d[10:8] = writedata[2:0];
                    load_pending_d   = 1'b1;
                end
                ADDR_SHY_LO: begin
                    shadow_y_d[7:0] = writedata;
                    load_pending_d  = 1'b1;
                end
                ADDR_SHY_HI: begin
                    shadow_y_d[9:8] = writedata[1:0];
                    load_pending_d  = 1'b1;
                end
                ADDR_DIR: begin
                    dir_x_d = writedata[DIR_X_BIT];
                    dir_y_d = writedata[DIR_Y_BIT];
                end
                default: ;
            endcase
        end

        // A reflection overrides a same-cycle dir write on that axis
        if (state_q == MOVE_X && x_hit)
            dir_x_d = x_next_dir;
        if (state_q == MOVE_Y && y_hit)
            dir_y_d = y_next_dir;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            ball_x_q       <= 11'(INIT_X);
            ball_y_q       <= 10'(INIT_Y);
            speed_x_q      <= 4'd1;
            speed_y_q      <= 4'd1;
            dir_x_q        <= 1'b0;
            dir_y_q        <= 1'b0;
            run_q          <= 1'b0;
            step_pending_q <= 1'b0;
            load_pending_q <= 1'b0;
            shadow_x_q     <= 11'(INIT_X);
            shadow_y_q     <= 10'(INIT_Y);
            vcount_prev_q  <= 10'd0;
            bounce_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            ball_x_q       <= ball_x_d;
            ball_y_q       <= ball_y_d;
            speed_x_q      <= speed_x_d;
            speed_y_q      <= speed_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            run_q          <= run_d;
            step_pending_q <= step_pending_d;
            load_pending_q <= load_pending_d;
            shadow_x_q     <= shadow_x_d;
            shadow_y_q     <= shadow_y_d;
            vcount_prev_q  <= vcount;
            bounce_q       <= bounce_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign frame_tick = tick;
    assign bounce     = bounce_q;

endmodule

// File: tb/tb_ball_motion.sv
// Bench for ball_motion: a stimulus process writes registers and queues the
// expected post-frame position and bounce count; a monitor process checks each
// frame tick against the queue, the tick spacing, and output stability.
module tb_ball_motion;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  writedata;
    logic        write;
    logic        chipselect;
    logic [2:0]  address;
    logic [9:0]  vcount;
    logic [10:0] ball_x;
    logic [9:0]  ball_y;
    logic        frame_tick;
    logic        bounce;

    typedef struct {
        int x;
        int y;
        int b;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   vc_en    = 0;
    bit   mon_en   = 0;
    bit   done     = 0;
    int   stab_viol = 0;

    ball_motion dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .writedata  (writedata),
        .write      (write),
        .chipselect (chipselect),
        .address    (address),
        .vcount     (vcount),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .frame_tick (frame_tick),
        .bounce     (bounce)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, got, want);
        end
    endtask

    // One line per clock, 525 lines per frame
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (vc_en)
                vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        end
    end

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic wait_vc(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (vcount != 10'(v) && n < 2000);
        if (vcount != 10'(v)) begin
            checks++;
            failures++;
            $display("FAIL wait_vcount got=%0d expected=%0d", vcount, v);
        end
    endtask

    task automatic frame(input int x, input int y, input int b);
        exp_t e;
        e.x = x;
        e.y = y;
        e.b = b;
        exp_q.push_back(e);
        wait_vc(500);
    endtask

    // Monitor: compares 4 cycles after every tick, counts bounce pulses in
    // that window, and flags any output change outside it.
    initial begin
        int   win;
        int   bcnt;
        int   gap;
        bit   seen;
        int   last_x;
        int   last_y;
        exp_t e;
        win    = 0;
        bcnt   = 0;
        gap    = 0;
        seen   = 0;
        last_x = 400;
        last_y = 300;
        wait (mon_en);
        while (!done) begin
            @(negedge clk);
            gap++;
            if (win != 0) begin
                if (bounce)
                    bcnt++;
                if (win == 4) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_tick got=(%0d,%0d) expected=none", ball_x, ball_y);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ball_x", int'(ball_x), e.x);
                        chk("ball_y", int'(ball_y), e.y);
                        chk("bounce_pulses", bcnt, e.b);
                    end
                    win = 0;
                end else begin
                    win++;
                end
            end else if (int'(ball_x) != last_x || int'(ball_y) != last_y) begin
                stab_viol++;
                $display("FAIL out_of_window_change got=(%0d,%0d) expected=(%0d,%0d)",
                         ball_x, ball_y, last_x, last_y);
            end
            if (frame_tick) begin
                if (seen)
                    chk("tick_spacing", gap, 525);
                seen = 1;
                gap  = 0;
                win  = 1;
                bcnt = 0;
            end
            last_x = int'(ball_x);
            last_y = int'(ball_y);
        end
    end

    initial begin
        reset_n    = 1'b0;
        writedata  = 8'd0;
        write      = 1'b0;
        chipselect = 1'b0;
        address    = 3'd0;
        vcount     = 10'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ball_x", int'(ball_x), 400);
        chk("reset_ball_y", int'(ball_y), 300);
        chk("reset_bounce", int'(bounce), 0);
        chk("reset_frame_tick", int'(frame_tick), 0);
        reset_n = 1'b1;
        mon_en  = 1;
        vc_en   = 1;
        wait_vc(10);

        // Free run at speed 1
        wr(3'd0, 8'h01);
        frame(401, 301, 0);
        frame(402, 302, 0);
        frame(403, 303, 0);

        // Load X=605 (Y shadow still 300), speed_x=5, bounce at right edge
        wr(3'd3, 8'h5D);
        wr(3'd4, 8'h02);
        wr(3'd1, 8'h05);
        frame(605, 300, 0);
        frame(609, 301, 1);
        frame(604, 302, 0);

        // Out-of-range loads clamp; stop running
        wr(3'd3, 8'hD0);
        wr(3'd4, 8'h07);
        wr(3'd5, 8'h05);
        wr(3'd6, 8'h00);
        wr(3'd0, 8'h00);
        frame(609, 30, 0);

        // Two step requests give a single step
        wr(3'd0, 8'h02);
        wr(3'd0, 8'h02);
        frame(604, 31, 0);
        frame(604, 31, 0);

        // speed_x=0 at the right edge holds position and direction
        wr(3'd3, 8'h61);
        wr(3'd4, 8'h02);
        wr(3'd7, 8'h00);
        wr(3'd1, 8'h00);
        frame(609, 30, 0);
        wr(3'd0, 8'h01);
        frame(609, 31, 0);
        wr(3'd1, 8'h01);
        frame(609, 32, 1);

        // Corner: both axes reflect in the same frame
        wr(3'd3, 8'd31);
        wr(3'd4, 8'h00);
        wr(3'd5, 8'd31);
        wr(3'd6, 8'h00);
        wr(3'd7, 8'h03);
        frame(31, 31, 0);
        frame(30, 30, 2);
        frame(31, 31, 0);

        // Reset during MOVE_Y
        begin
            exp_t e;
            e.x = 400;
            e.y = 300;
            e.b = 0;
            exp_q.push_back(e);
        end
        wait_vc(482);
        reset_n = 1'b0;
        #1;
        chk("midreset_ball_x", int'(ball_x), 400);
        chk("midreset_ball_y", int'(ball_y), 300);
        chk("midreset_bounce", int'(bounce), 0);
        wait_vc(486);
        reset_n = 1'b1;
        wait_vc(500);
        frame(400, 300, 0);

        done = 1;
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("stability_violations", stab_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + stab_viol);
        $finish;
    end

endmodule
